// File: rtl/masked_pkg.sv
// Shared types and encodings for the masked Boolean gate datapath.
package masked_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  // Two-share representation of one DATA_W-bit value (value = s0 ^ s1).
  typedef struct packed {
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s0;
  } share_t;

  function automatic int unsigned rnd_width(input int unsigned width);
    return 3 * width;
  endfunction

endpackage

// File: rtl/dom_and2.sv
// WIDTH-bit two-share DOM AND; inner and cross-domain products are registered together.
module dom_and2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] z0_c,
  output logic [WIDTH-1:0] z1_c
);

  logic [WIDTH-1:0] inner0_q, inner0_d, inner1_q, inner1_d;
  logic [WIDTH-1:0] cross0_q, cross0_d, cross1_q, cross1_d;

  always_comb begin
    inner0_d = inner0_q;
    inner1_d = inner1_q;
    cross0_d = cross0_q;
    cross1_d = cross1_q;
    if (en) begin
      inner0_d = x0 & y0;
      inner1_d = x1 & y1;
      cross0_d = (x0 & y1) ^ r;
      cross1_d = (x1 & y0) ^ r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inner0_q <= '0;
      inner1_q <= '0;
      cross0_q <= '0;
      cross1_q <= '0;
    end else begin
      inner0_q <= inner0_d;
      inner1_q <= inner1_d;
      cross0_q <= cross0_d;
      cross1_q <= cross1_d;
    end
  end

  // Recombination only ever mixes registers of the same domain.
  assign z0_c = inner0_q ^ cross0_q;
  assign z1_c = inner1_q ^ cross1_q;

endmodule

// File: rtl/masked_gate_pipe.sv
// Pipelined two-share masked AND/OR/XOR/XNOR gate with valid/ready handshakes.
module masked_gate_pipe
  import masked_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    op,
  input  logic [WIDTH-1:0]              a0,
  input  logic [WIDTH-1:0]              a1,
  input  logic [WIDTH-1:0]              b0,
  input  logic [WIDTH-1:0]              b1,
  input  logic [rnd_width(WIDTH)-1:0]   rnd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              y0,
  output logic [WIDTH-1:0]              y1
);

  logic advance, accept, en2, en3, inv;
  op_e  op_in, op1_q, op1_d, op2_q, op2_d;
  logic v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
  logic [WIDTH-1:0] r0, r1, r2, r2_q, r2_d;
  logic [WIDTH-1:0] pa0, pa1, pb0, pb1, qa0, qa1, qb0, qb1, rq;
  logic [WIDTH-1:0] p0_c, p1_c, q0_c, q1_c, f0_c, f1_c;
  logic [WIDTH-1:0] lin0_q, lin0_d, lin1_q, lin1_d, y0_q, y0_d, y1_q, y1_d;

  assign op_in = op_e'(op);
  assign r0 = rnd[WIDTH-1:0];
  assign r1 = rnd[2*WIDTH-1:WIDTH];
  assign r2 = rnd[3*WIDTH-1:2*WIDTH];

  // Global stall: every stage moves only when the output slot frees up.
  assign advance  = ~ov_q | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;
  assign en2      = advance & v1_q;
  assign en3      = advance & v2_q;
  assign inv      = (op2_q == OP_OR) || (op2_q == OP_XNOR);

  // Stage-1 operand selection; masked negation flips share 0 only.
  always_comb begin
    pa0 = a0;
    pa1 = a1;
    pb0 = b0;
    pb1 = b1;
    qa0 = '0;
    qa1 = '0;
    qb0 = '0;
    qb1 = '0;
    rq  = '0;
    case (op_in)
      OP_AND: ;
      OP_OR: begin
        pa0 = ~a0;
        pb0 = ~b0;
      end
      default: begin
        pa0 = ~a0;
        qa0 = a0;
        qa1 = a1;
        qb0 = ~b0;
        qb1 = b1;
        rq  = r1;
      end
    endcase
  end

  dom_and2 #(.WIDTH(WIDTH)) u_dom_p (
    .clk(clk), .rst_n(rst_n), .en(accept),
    .x0(pa0), .x1(pa1), .y0(pb0), .y1(pb1), .r(r0),
    .z0_c(p0_c), .z1_c(p1_c)
  );

  dom_and2 #(.WIDTH(WIDTH)) u_dom_q (
    .clk(clk), .rst_n(rst_n), .en(accept),
    .x0(qa0), .x1(qa1), .y0(qb0), .y1(qb1), .r(rq),
    .z0_c(q0_c), .z1_c(q1_c)
  );

  dom_and2 #(.WIDTH(WIDTH)) u_dom_f (
    .clk(clk), .rst_n(rst_n), .en(en2),
    .x0(p0_c), .x1(p1_c), .y0(q0_c), .y1(q1_c), .r(r2_q),
    .z0_c(f0_c), .z1_c(f1_c)
  );

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    ov_d   = ov_q;
    r2_d   = r2_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    lin0_d = lin0_q;
    lin1_d = lin1_q;
    y0_d   = y0_q;
    y1_d   = y1_q;
    if (advance) begin
      v1_d = in_valid;
      v2_d = v1_q;
      ov_d = v2_q;
    end
    if (accept) begin
      r2_d  = r2;
      op1_d = op_in;
    end
    if (en2) begin
      lin0_d = p0_c ^ q0_c;
      lin1_d = p1_c ^ q1_c;
      op2_d  = op1_q;
    end
    if (en3) begin
      y0_d = lin0_q ^ f0_c ^ {WIDTH{inv}};
      y1_d = lin1_q ^ f1_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ov_q   <= 1'b0;
      r2_q   <= '0;
      op1_q  <= OP_AND;
      op2_q  <= OP_AND;
      lin0_q <= '0;
      lin1_q <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      ov_q   <= ov_d;
      r2_q   <= r2_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      lin0_q <= lin0_d;
      lin1_q <= lin1_d;
      y0_q   <= y0_d;
      y1_q   <= y1_d;
    end
  end

  assign out_valid = ov_q;
  assign y0        = y0_q;
  assign y1        = y1_q;

endmodule
